// File: rtl/dds_cfg_ctrl_if.sv
// Write/commit handshake bundle between the parameter source and dds_cfg_ctrl.
// master = parameter source, slave = configuration controller.
interface dds_cfg_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_ch;
    logic       cfg_wave;
    logic [7:0] cfg_freq;
    logic [5:0] cfg_phase;
    logic       commit;
    logic       cfg_err;
    logic       commit_drop;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_wave,
        output cfg_freq,
        output cfg_phase,
        output commit,
        input  cfg_ready,
        input  cfg_err,
        input  commit_drop
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_wave,
        input  cfg_freq,
        input  cfg_phase,
        input  commit,
        output cfg_ready,
        output cfg_err,
        output commit_drop
    );
endinterface

// File: rtl/dds_cfg_ctrl.sv
// Dual-channel DDS configuration controller: shadowed writes, atomic apply, settle lockout.
// Define DDS_CFG_AUTO_COMMIT_EN to make every good write commit itself.
module dds_cfg_ctrl #(
    parameter int unsigned SETTLE_CYC = 2000,
    parameter logic [7:0]  FREQ_RST   = 8'd1
) (
    input  logic           clk,
    input  logic           rst,
    dds_cfg_ctrl_if.slave  cfg,
    output logic           busy,
    output logic           upd_strobe,
    output logic           wave_select1,
    output logic           wave_select2,
    output logic [7:0]     freq_select1,
    output logic [7:0]     freq_select2,
    output logic [5:0]     phase_select1,
    output logic [5:0]     phase_select2
);

    localparam int unsigned    CntW    = $clog2(SETTLE_CYC + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYC - 1);

`ifdef DDS_CFG_AUTO_COMMIT_EN
    localparam bit AutoCommit = 1'b1;
`else
    localparam bit AutoCommit = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StApply, StSettle} state_e;

    state_e               state_q, state_d;
    logic [1:0]           dirty_q, dirty_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           sh_wave_q, sh_wave_d;
    logic [1:0][7:0]      sh_freq_q, sh_freq_d;
    logic [1:0][5:0]      sh_phase_q, sh_phase_d;
    logic [1:0]           act_wave_q, act_wave_d;
    logic [1:0][7:0]      act_freq_q, act_freq_d;
    logic [1:0][5:0]      act_phase_q, act_phase_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 commit_drop_q, commit_drop_d;
    logic                 upd_strobe_q, upd_strobe_d;

    logic wr_acc;
    logic wr_ok;
    logic commit_req;

    assign wr_acc     = cfg.cfg_valid & (state_q == StIdle);
    assign wr_ok      = wr_acc & (cfg.cfg_freq != 8'd0);
    assign commit_req = cfg.commit | (AutoCommit & wr_ok);

    always_comb begin
        state_d       = state_q;
        dirty_d       = dirty_q;
        cnt_d         = cnt_q;
        sh_wave_d     = sh_wave_q;
        sh_freq_d     = sh_freq_q;
        sh_phase_d    = sh_phase_q;
        act_wave_d    = act_wave_q;
        act_freq_d    = act_freq_q;
        act_phase_d   = act_phase_q;
        cfg_err_d     = 1'b0;
        commit_drop_d = 1'b0;
        upd_strobe_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_ok) begin
                    sh_wave_d[cfg.cfg_ch]  = cfg.cfg_wave;
                    sh_freq_d[cfg.cfg_ch]  = cfg.cfg_freq;
                    sh_phase_d[cfg.cfg_ch] = cfg.cfg_phase;
                    dirty_d[cfg.cfg_ch]    = 1'b1;
                end else if (wr_acc) begin
                    cfg_err_d = 1'b1;
                end
                // dirty_d already includes this cycle's write, so write+commit applies together.
                if (commit_req && (dirty_d != 2'b00)) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                for (int i = 0; i < 2; i++) begin
                    if (dirty_q[i]) begin
                        act_wave_d[i]  = sh_wave_q[i];
                        act_freq_d[i]  = sh_freq_q[i];
                        act_phase_d[i] = sh_phase_q[i];
                    end
                end
                dirty_d       = 2'b00;
                cnt_d         = CntLoad;
                upd_strobe_d  = 1'b1;
                commit_drop_d = cfg.commit;
                state_d       = StSettle;
            end
            StSettle: begin
                commit_drop_d = cfg.commit;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            dirty_q       <= 2'b00;
            cnt_q         <= '0;
            sh_wave_q     <= 2'b00;
            sh_freq_q     <= {2{FREQ_RST}};
            sh_phase_q    <= '0;
            act_wave_q    <= 2'b00;
            act_freq_q    <= {2{FREQ_RST}};
            act_phase_q   <= '0;
            cfg_err_q     <= 1'b0;
            commit_drop_q <= 1'b0;
            upd_strobe_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            dirty_q       <= dirty_d;
            cnt_q         <= cnt_d;
            sh_wave_q     <= sh_wave_d;
            sh_freq_q     <= sh_freq_d;
            sh_phase_q    <= sh_phase_d;
            act_wave_q    <= act_wave_d;
            act_freq_q    <= act_freq_d;
            act_phase_q   <= act_phase_d;
            cfg_err_q     <= cfg_err_d;
            commit_drop_q <= commit_drop_d;
            upd_strobe_q  <= upd_strobe_d;
        end
    end

    assign cfg.cfg_ready   = (state_q == StIdle);
    assign cfg.cfg_err     = cfg_err_q;
    assign cfg.commit_drop = commit_drop_q;
    assign busy            = (state_q != StIdle);
    assign upd_strobe      = upd_strobe_q;
    assign wave_select1    = act_wave_q[0];
    assign wave_select2    = act_wave_q[1];
    assign freq_select1    = act_freq_q[0];
    assign freq_select2    = act_freq_q[1];
    assign phase_select1   = act_phase_q[0];
    assign phase_select2   = act_phase_q[1];

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Scoreboard bench for dds_cfg_ctrl: transaction-level model predicts timed events,
// a negedge monitor pops and compares them against the DUT.
module tb_dds_cfg_ctrl;

    localparam int unsigned SettleCyc = 4;
    localparam logic [7:0]  FreqRst   = 8'd1;
    localparam int          MaxCyc    = 8192;
`ifdef DDS_CFG_AUTO_COMMIT_EN
    localparam bit Auto = 1'b1;
`else
    localparam bit Auto = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_cfg_ctrl_if ifc ();

    logic       busy, upd_strobe;
    logic       wave_select1, wave_select2;
    logic [7:0] freq_select1, freq_select2;
    logic [5:0] phase_select1, phase_select2;

    dds_cfg_ctrl #(
        .SETTLE_CYC (SettleCyc),
        .FREQ_RST   (FreqRst)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg           (ifc),
        .busy          (busy),
        .upd_strobe    (upd_strobe),
        .wave_select1  (wave_select1),
        .wave_select2  (wave_select2),
        .freq_select1  (freq_select1),
        .freq_select2  (freq_select2),
        .phase_select1 (phase_select1),
        .phase_select2 (phase_select2)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    bit run   = 1'b0;
    bit busy_at [0:MaxCyc-1];

    typedef struct {
        int          cyc;
        logic [29:0] vals;
    } upd_t;

    upd_t upd_q [$];
    int   err_q [$];
    int   drop_q [$];

    // Reference model: shadow and active settings per channel, plus pending-channel flags.
    logic       m_sw [2];
    logic [7:0] m_sf [2];
    logic [5:0] m_sp [2];
    logic       m_aw [2];
    logic [7:0] m_af [2];
    logic [5:0] m_ap [2];
    logic [1:0] m_dirty;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [29:0] model_act();
        return {m_aw[0], m_af[0], m_ap[0], m_aw[1], m_af[1], m_ap[1]};
    endfunction

    function automatic logic [29:0] dut_act();
        return {wave_select1, freq_select1, phase_select1,
                wave_select2, freq_select2, phase_select2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sw[i] = 1'b0; m_sf[i] = FreqRst; m_sp[i] = 6'd0;
            m_aw[i] = 1'b0; m_af[i] = FreqRst; m_ap[i] = 6'd0;
        end
        m_dirty = 2'b00;
    endtask

    // Drive one cycle of stimulus for the next edge and record what the model expects from it.
    task automatic op(input bit v, input bit ch, input bit w, input logic [7:0] f,
                      input logic [5:0] p, input bit cm);
        int e;
        e = cyc + 1;
        ifc.cfg_valid = v;
        ifc.cfg_ch    = ch;
        ifc.cfg_wave  = w;
        ifc.cfg_freq  = f;
        ifc.cfg_phase = p;
        ifc.commit    = cm;
        if (!busy_at[e]) begin
            if (v) begin
                if (f != 8'd0) begin
                    m_sw[ch] = w; m_sf[ch] = f; m_sp[ch] = p;
                    m_dirty[ch] = 1'b1;
                end else begin
                    err_q.push_back(e);
                end
            end
            if ((cm || (Auto && v && f != 8'd0)) && m_dirty != 2'b00) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_dirty[i]) begin
                        m_aw[i] = m_sw[i]; m_af[i] = m_sf[i]; m_ap[i] = m_sp[i];
                    end
                end
                m_dirty = 2'b00;
                upd_q.push_back('{cyc: e + 1, vals: model_act()});
                for (int k = e + 1; k <= e + 1 + int'(SettleCyc); k++) busy_at[k] = 1'b1;
            end
        end else if (cm) begin
            drop_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        rst = 1'b1;
        ifc.cfg_valid = 1'b0;
        ifc.commit    = 1'b0;
        model_reset();
        upd_q.delete();
        err_q.delete();
        drop_q.delete();
        for (int k = cyc + 1; k < MaxCyc; k++) busy_at[k] = 1'b0;
        #1;
        chk("rst_actives", 32'(dut_act()), 32'(model_act()));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ifc.cfg_ready), 32'd1);
        chk("rst_pulses", {29'd0, upd_strobe, ifc.cfg_err, ifc.commit_drop}, 32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle compare handshake state and consume any pulse the DUT shows.
    always @(negedge clk) begin
        if (run && !rst) begin
            int   c;
            upd_t u;
            int   x;
            c = cyc;
            chk("busy", 32'(busy), 32'(busy_at[c + 1]));
            chk("cfg_ready", 32'(ifc.cfg_ready), 32'(!busy_at[c + 1]));

            while (upd_q.size() > 0 && upd_q[0].cyc < c) begin
                u = upd_q.pop_front();
                chk("upd_missed_at", 32'(c), 32'(u.cyc));
            end
            if (upd_strobe) begin
                if (upd_q.size() == 0) begin
                    chk("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    u = upd_q.pop_front();
                    chk("upd_cycle", 32'(c), 32'(u.cyc));
                    chk("upd_actives", 32'(dut_act()), 32'(u.vals));
                end
            end

            while (err_q.size() > 0 && err_q[0] < c) begin
                x = err_q.pop_front();
                chk("err_missed_at", 32'(c), 32'(x));
            end
            if (ifc.cfg_err) begin
                if (err_q.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
                else begin
                    x = err_q.pop_front();
                    chk("err_cycle", 32'(c), 32'(x));
                end
            end

            while (drop_q.size() > 0 && drop_q[0] < c) begin
                x = drop_q.pop_front();
                chk("drop_missed_at", 32'(c), 32'(x));
            end
            if (ifc.commit_drop) begin
                if (drop_q.size() == 0) chk("drop_unexpected", 32'd1, 32'd0);
                else begin
                    x = drop_q.pop_front();
                    chk("drop_cycle", 32'(c), 32'(x));
                end
            end
        end
    end

    initial begin
        ifc.cfg_valid = 1'b0;
        ifc.cfg_ch    = 1'b0;
        ifc.cfg_wave  = 1'b0;
        ifc.cfg_freq  = 8'd0;
        ifc.cfg_phase = 6'd0;
        ifc.commit    = 1'b0;
        for (int k = 0; k < MaxCyc; k++) busy_at[k] = 1'b0;
        model_reset();
        #2;
        do_reset(3);
        run = 1'b1;

        // Quiet after reset: defaults hold.
        idle(3);
        chk("idle_actives", 32'(dut_act()), {2'b00, 1'b0, FreqRst, 6'd0, 1'b0, FreqRst, 6'd0});

        // Single ch0 write, commit three cycles later.
        op(1'b1, 1'b0, 1'b1, 8'd25, 6'd16, 1'b0);
        idle(2);
        op(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b1);
        idle(8);

        // Both channels, commit alongside a second ch1 write.
        op(1'b1, 1'b0, 1'b0, 8'd10, 6'd1, 1'b0);
        op(1'b1, 1'b1, 1'b0, 8'd20, 6'd2, 1'b0);
        op(1'b1, 1'b1, 1'b1, 8'd30, 6'd3, 1'b1);
        idle(8);
        chk("dual_freq", {16'd0, freq_select1, freq_select2}, {16'd0, 8'd10, 8'd30});

        // Illegal freq write, then a commit with nothing pending.
        op(1'b1, 1'b0, 1'b1, 8'd0, 6'd5, 1'b0);
        op(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b1);
        idle(4);

        // Commit during settle is dropped.
        op(1'b1, 1'b1, 1'b0, 8'd77, 6'd7, 1'b1);
        idle(2);
        op(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b1);
        idle(7);

        // Reset during settle with a write held.
        op(1'b1, 1'b0, 1'b1, 8'd99, 6'd9, 1'b1);
        op(1'b1, 1'b1, 1'b1, 8'd55, 6'd5, 1'b0);
        op(1'b1, 1'b1, 1'b1, 8'd55, 6'd5, 1'b0);
        do_reset(2);
        op(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b1);
        idle(4);

        // Reset with a dirty shadow in idle.
        op(1'b1, 1'b0, 1'b1, 8'd60, 6'd6, 1'b0);
        do_reset(1);
        op(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b1);
        idle(4);

        // Lone ch1 write: applies by itself only in the auto-commit build.
        op(1'b1, 1'b1, 1'b0, 8'd40, 6'd4, 1'b0);
        idle(7);

        for (int i = 0; i < 400; i++) begin
            bit         v, ch, w, cm;
            logic [7:0] f;
            logic [5:0] p;
            v  = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            p  = 6'($urandom_range(0, 63));
            cm = ($urandom_range(0, 5) == 0);
            op(v, ch, w, f, p, cm);
        end
        idle(12);

        chk("leftover_upd", 32'(upd_q.size()), 32'd0);
        chk("leftover_err", 32'(err_q.size()), 32'd0);
        chk("leftover_drop", 32'(drop_q.size()), 32'd0);
        chk("final_actives", 32'(dut_act()), 32'(model_act()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dds_cfg_ctrl.md
Name: dds_cfg_ctrl

Overview:
- Configuration controller for the dual-channel DDS. It sits between the parameter source (measurement, key or UART logic) and the two wave-send datapaths.
- Accepts per-channel write requests (wave, freq, phase) over a valid/ready handshake into shadow registers.
- On commit, updates both channels' active selects in the same cycle, then blocks new writes for a settle interval so the DACs can stabilise.

Parameters:
- SETTLE_CYC, 2000, cycles of write blocking after an apply (20 us at 100 MHz); legal range >= 1.
- FREQ_RST, 8'd1, reset/default value of both freq_select outputs.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_valid  in  1  write request valid.
- cfg_ready  out  1  controller can accept a write.
- cfg_ch  in  1  target channel: 0 = channel 1, 1 = channel 2.
- cfg_wave  in  1  requested wave select.
- cfg_freq  in  8  requested freq select; 0 is illegal.
- cfg_phase  in  6  requested phase select.
- commit  in  1  single-cycle request to apply pending shadows.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_freq == 0 and was discarded.
- commit_drop  out  1  one-cycle pulse: commit arrived while busy and was ignored.
- busy  out  1  state != IDLE.
- upd_strobe  out  1  one-cycle pulse in the first cycle new active values are driven.
- wave_select1 / wave_select2  out  1  active wave select per channel.
- freq_select1 / freq_select2  out  8  active freq select per channel.
- phase_select1 / phase_select2  out  6  active phase select per channel.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; dirty[1:0] = 0; settle counter = 0.
  - Shadows and actives: wave = 0, freq = FREQ_RST, phase = 0.
  - cfg_err, commit_drop, upd_strobe = 0.
  - cfg_ready = 1 after reset deasserts.
- Reset mid-SETTLE or mid-APPLY returns immediately to the reset values; pending dirty shadows are lost.
- FSM states: IDLE, APPLY, SETTLE. cfg_ready is high only in IDLE and is combinational from state.
- IDLE, write accepted (cfg_valid & cfg_ready at edge t):
  - If cfg_freq != 0: the shadow for cfg_ch takes wave/freq/phase at t+1 and dirty[cfg_ch] is set.
  - If cfg_freq == 0: no shadow write, dirty unchanged, cfg_err = 1 during cycle t+1 only.
- IDLE, commit at edge t:
  - If dirty != 0 after this edge's write, go to APPLY at t+1. A write and commit in the same cycle means the write is included in that commit.
  - If dirty stays 0, commit is ignored silently and the state stays IDLE.
- APPLY (one cycle):
  - At the closing edge, copy shadow to active for each dirty channel only; non-dirty channels keep their actives.
  - Clear dirty; load counter = SETTLE_CYC-1; go to SETTLE.
  - New actives and upd_strobe appear together at t+2.
- SETTLE:
  - Decrement the counter each cycle. When the counter is 0 at an edge, go to IDLE.
  - SETTLE lasts exactly SETTLE_CYC cycles, so IDLE and cfg_ready = 1 return at t+2+SETTLE_CYC.
- commit while busy (APPLY or SETTLE): ignored and not queued; commit_drop pulses the next cycle.
- Counter width is $clog2(SETTLE_CYC+1). No wrap-around is possible.
- Writes to the same channel before a commit overwrite the shadow; last write wins.
- All outputs are registered except cfg_ready and busy.

Optional Feature:
- Macro: DDS_CFG_AUTO_COMMIT_EN.
- Defined: every write accepted with cfg_freq != 0 is treated as if commit were asserted in the same cycle. The commit input is still honoured, and dropped-commit reporting is unchanged.
- Undefined: shadows apply only on an explicit commit.

Test Plan (bench uses SETTLE_CYC = 4):
- Reset release, no stimulus -> all freq_select = 1, phase = 0, wave = 0, cfg_ready = 1, busy = 0, no strobes.
- Write ch0 (wave=1, freq=8'd25, phase=6'd16) at edge t, commit at edge t+3 -> freq_select1 = 25, phase_select1 = 16, wave_select1 = 1 and upd_strobe at t+5; channel 2 unchanged; cfg_ready low t+4..t+8, high at t+9.
- Write ch0 freq=10 and ch1 freq=20 on consecutive cycles, then commit in the same cycle as a second ch1 write of freq=30 -> both channels change on the same cycle: freq_select1 = 10, freq_select2 = 30; single upd_strobe.
- Write with cfg_freq = 0 -> cfg_err one cycle; dirty stays 0; a following commit produces no APPLY, no upd_strobe, busy stays 0.
- Commit pulsed during SETTLE -> commit_drop one cycle later; no second APPLY; IDLE at the nominal time.
- Assert rst during SETTLE with a write pending -> all outputs at reset values asynchronously; after release cfg_ready = 1 and dirty = 0 (a commit does nothing).
- DDS_CFG_AUTO_COMMIT_EN build: single ch1 write freq = 40 at edge t -> freq_select2 = 40 with upd_strobe at t+2, with no commit pulse.
